// File: rtl/elastic_stage_pkg.sv
// elastic_stage_pkg: width helpers and pointer wrap function shared by the
// elastic pipeline stage and its storage array.
package elastic_stage_pkg;

    // Pointer width: at least one bit, even for a single-entry stage.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Circular increment with an explicit compare, so depth need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/elastic_stage_mem.sv
// elastic_stage_mem: DEPTH x WIDTH register array, one write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module elastic_stage_mem #(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: address decoded by compare so no out-of-range index exists.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_we && (i_waddr == PTR_W'(i))) begin
                r_mem[i] <= i_wdata;
            end
        end
    end

    // Read port: mux over valid entries only.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_raddr == PTR_W'(i)) begin
                o_rdata = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/elastic_stage.sv
// elastic_stage: elastic pipeline stage holding up to DEPTH entries in a
// circular buffer, with synchronous squash and occupancy count.
//   clk       : clock, rising edge
//   reset     : synchronous active-low reset
//   flush     : squash all held entries, drop any concurrent input
//   valid_in  : upstream offers data_in
//   data_in   : upstream payload
//   allow_out : stage accepts data_in this cycle
//   ready_go  : head entry has finished its work here
//   nop_data  : payload shown on data_out when empty
//   allow_in  : downstream accepts data_out this cycle
//   valid_out : head entry offered downstream
//   data_out  : head payload, or nop_data when empty
//   count     : number of held entries
module elastic_stage #(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         valid_in,
    input  logic [WIDTH-1:0]             data_in,
    output logic                         allow_out,
    input  logic                         ready_go,
    input  logic [WIDTH-1:0]             nop_data,
    input  logic                         allow_in,
    output logic                         valid_out,
    output logic [WIDTH-1:0]             data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    import elastic_stage_pkg::*;

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_enq;
    logic             w_deq;
    logic             w_empty;
    logic [WIDTH-1:0] w_rdata;

    // Handshake and head presentation.
    assign w_empty   = (r_count == '0);
    assign valid_out = !w_empty && ready_go;
    assign data_out  = w_empty ? nop_data : w_rdata;
    assign w_enq     = valid_in && allow_out && !flush;
    assign w_deq     = valid_out && allow_in && !flush;
    assign count     = r_count;

    // Single entry keeps the classic pass-through allow; deeper stages decouple
    // allow_out from downstream so the allow chain is cut at this register.
    generate
        if (DEPTH == 1) begin : g_allow_single
            assign allow_out = w_empty || (valid_out && allow_in);
        end else begin : g_allow_decoupled
            assign allow_out = (r_count != CNT_W'(DEPTH));
        end
    endgenerate

    // Pointers and occupancy; reset outranks flush, flush outranks traffic.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= PTR_W'(wrap_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_deq) begin
                r_rd_ptr <= PTR_W'(wrap_inc(32'(r_rd_ptr), DEPTH));
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    elastic_stage_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_elastic_stage.sv
// tb_elastic_stage: drives four elastic_stage instances (DEPTH 1..4) from shared
// inputs and compares each against a queue-style reference model, plus a
// directed vector table and hand-written corner-case sequences.
module tb_elastic_stage;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         valid_in;
    logic [W-1:0] data_in;
    logic         ready_go;
    logic [W-1:0] nop_data;
    logic         allow_in;

    logic [3:0]   a_allow;
    logic [3:0]   a_valid;
    logic [W-1:0] a_data [4];
    logic [0:0]   c1;
    logic [1:0]   c2;
    logic [1:0]   c3;
    logic [2:0]   c4;
    logic [31:0]  a_cnt [4];

    always #5 clk = ~clk;

    always_comb begin
        a_cnt[0] = 32'(c1);
        a_cnt[1] = 32'(c2);
        a_cnt[2] = 32'(c3);
        a_cnt[3] = 32'(c4);
    end

    elastic_stage #(.WIDTH(W), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .data_in(data_in),
        .allow_out(a_allow[0]), .ready_go(ready_go), .nop_data(nop_data), .allow_in(allow_in),
        .valid_out(a_valid[0]), .data_out(a_data[0]), .count(c1));
    elastic_stage #(.WIDTH(W), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .data_in(data_in),
        .allow_out(a_allow[1]), .ready_go(ready_go), .nop_data(nop_data), .allow_in(allow_in),
        .valid_out(a_valid[1]), .data_out(a_data[1]), .count(c2));
    elastic_stage #(.WIDTH(W), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .data_in(data_in),
        .allow_out(a_allow[2]), .ready_go(ready_go), .nop_data(nop_data), .allow_in(allow_in),
        .valid_out(a_valid[2]), .data_out(a_data[2]), .count(c3));
    elastic_stage #(.WIDTH(W), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .data_in(data_in),
        .allow_out(a_allow[3]), .ready_go(ready_go), .nop_data(nop_data), .allow_in(allow_in),
        .valid_out(a_valid[3]), .data_out(a_data[3]), .count(c4));

    // Reference model: an ordered list per instance, head at index 0.
    int           m_n [4];
    logic [W-1:0] m_q [4][16];
    bit           model_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic m_valid(input int i);
        return (m_n[i] != 0) && ready_go;
    endfunction

    function automatic logic m_allow(input int i);
        if (i == 0) return (m_n[i] == 0) || (m_valid(i) && allow_in);
        return m_n[i] != (i + 1);
    endfunction

    function automatic logic [W-1:0] m_data(input int i);
        return (m_n[i] != 0) ? m_q[i][0] : nop_data;
    endfunction

    task automatic model_step();
        bit enq [4];
        bit deq [4];
        for (int i = 0; i < 4; i++) begin
            enq[i] = valid_in && m_allow(i) && !flush;
            deq[i] = m_valid(i) && allow_in && !flush;
        end
        for (int i = 0; i < 4; i++) begin
            if (!reset || flush) begin
                m_n[i] = 0;
            end else begin
                if (deq[i]) begin
                    for (int j = 0; j < 15; j++) m_q[i][j] = m_q[i][j+1];
                    m_n[i] = m_n[i] - 1;
                end
                if (enq[i]) begin
                    m_q[i][m_n[i]] = data_in;
                    m_n[i] = m_n[i] + 1;
                end
            end
        end
        if (!reset) model_valid = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_models();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("d%0d allow_out", i + 1), 32'(a_allow[i]), 32'(m_allow(i)));
            chk($sformatf("d%0d valid_out", i + 1), 32'(a_valid[i]), 32'(m_valid(i)));
            chk($sformatf("d%0d data_out", i + 1), 32'(a_data[i]), 32'(m_data(i)));
            chk($sformatf("d%0d count", i + 1), a_cnt[i], 32'(m_n[i]));
        end
    endtask

    // Inputs are set just after a falling edge; outputs are examined 1 ns later.
    task automatic settle();
        #1;
        if (model_valid) check_models();
    endtask

    task automatic clock();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; flush = 1'b0; valid_in = 1'b0; data_in = '0;
        ready_go = 1'b1; allow_in = 1'b0; nop_data = '0;
        repeat (2) begin settle(); clock(); end
        reset = 1'b1;
    endtask

    typedef struct {
        logic         rst_n;
        logic         fl;
        logic         vin;
        logic [W-1:0] din;
        logic         rg;
        logic         ain;
        logic [W-1:0] nop;
        logic         en;
        logic         e_allow;
        logic         e_valid;
        logic [W-1:0] e_data;
        int           e_cnt;
    } vec_t;

    vec_t         tbl [10];
    logic [W-1:0] got [$];
    int           k;

    initial begin
        // DEPTH=2 directed table: reset, fill/stall, rejected push, flush, refill.
        tbl[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 16'h000A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 16'h000B, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h000A, 1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 16'h000C, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h000A, 2};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h000A, 2};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 16'h000D, 1'b1, 1'b1, 16'h003C, 1'b1, 1'b1, 1'b0, 16'h003C, 0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h003C, 1'b1, 1'b1, 1'b1, 16'h000D, 1};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h003C, 1'b1, 1'b1, 1'b0, 16'h003C, 0};

        for (int r = 0; r < 10; r++) begin
            reset = tbl[r].rst_n; flush = tbl[r].fl; valid_in = tbl[r].vin;
            data_in = tbl[r].din; ready_go = tbl[r].rg; allow_in = tbl[r].ain;
            nop_data = tbl[r].nop;
            settle();
            if (tbl[r].en) begin
                chk($sformatf("tbl%0d allow_out", r), 32'(a_allow[1]), 32'(tbl[r].e_allow));
                chk($sformatf("tbl%0d valid_out", r), 32'(a_valid[1]), 32'(tbl[r].e_valid));
                chk($sformatf("tbl%0d data_out", r),  32'(a_data[1]),  32'(tbl[r].e_data));
                chk($sformatf("tbl%0d count", r),     a_cnt[1],        32'(tbl[r].e_cnt));
            end
            clock();
        end

        // DEPTH=1: full stage accepts and delivers in the same cycle.
        do_reset();
        valid_in = 1'b1; data_in = 16'h0004; allow_in = 1'b0;
        settle(); clock();
        valid_in = 1'b1; data_in = 16'h0005; allow_in = 1'b1;
        settle();
        chk("d1 full count", a_cnt[0], 32'd1);
        chk("d1 full allow_out", 32'(a_allow[0]), 32'd1);
        chk("d1 full data_out", 32'(a_data[0]), 32'h4);
        clock();
        valid_in = 1'b0; allow_in = 1'b0;
        settle();
        chk("d1 next data_out", 32'(a_data[0]), 32'h5);
        chk("d1 next count", a_cnt[0], 32'd1);
        clock();

        // DEPTH=3 stream: 8 entries after a 2-cycle stall, order preserved.
        do_reset();
        k = 0;
        got.delete();
        for (int c = 0; c < 60 && got.size() < 8; c++) begin
            allow_in = (c >= 2);
            valid_in = (k < 8);
            data_in  = W'(k + 1);
            settle();
            if (valid_in && m_allow(2)) k++;
            if (a_valid[2] && allow_in) got.push_back(a_data[2]);
            clock();
        end
        chk("d3 stream length", 32'(got.size()), 32'd8);
        for (int j = 0; j < got.size() && j < 8; j++) begin
            chk($sformatf("d3 stream item%0d", j), 32'(got[j]), 32'(j + 1));
        end
        valid_in = 1'b0;
        settle();
        chk("d3 drained count", a_cnt[2], 32'd0);
        clock();

        // DEPTH=4 with ready_go low: fill, hold, then drain in order.
        do_reset();
        ready_go = 1'b0; allow_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; data_in = W'(16'h40 + i);
            settle();
            chk($sformatf("d4 fill allow%0d", i), 32'(a_allow[3]), 32'd1);
            clock();
        end
        valid_in = 1'b0;
        settle();
        chk("d4 full count", a_cnt[3], 32'd4);
        chk("d4 held valid_out", 32'(a_valid[3]), 32'd0);
        chk("d4 full allow_out", 32'(a_allow[3]), 32'd0);
        ready_go = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("d4 drain valid%0d", i), 32'(a_valid[3]), 32'd1);
            chk($sformatf("d4 drain data%0d", i), 32'(a_data[3]), 32'(16'h40 + i));
            chk($sformatf("d4 drain count%0d", i), a_cnt[3], 32'(4 - i));
            clock();
        end
        settle();
        chk("d4 empty count", a_cnt[3], 32'd0);
        clock();

        // Random traffic with occasional flush and mid-run reset.
        for (int c = 0; c < 500; c++) begin
            reset    = ($urandom_range(0, 39) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = W'($urandom);
            ready_go = ($urandom_range(0, 4) != 0);
            allow_in = ($urandom_range(0, 2) != 0);
            nop_data = W'($urandom);
            settle();
            clock();
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
